// File: rtl/rf_write_arbiter.sv
// Write-back arbiter for the dual-core shared register file.
// Each core's write-back requests are buffered in a private FIFO. The FIFO
// heads are steered onto the bank-A / bank-B write ports. When both heads
// target the same bank, a per-bank round-robin pointer picks the winner.
module rf_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid1,
  input  logic                    wb_valid2,
  output logic                    wb_ready1,
  output logic                    wb_ready2,
  input  logic                    wb_bank1,
  input  logic                    wb_bank2,
  input  logic [ADDR_W-1:0]       wb_addr1,
  input  logic [ADDR_W-1:0]       wb_addr2,
  input  logic [DATA_W-1:0]       wb_data1,
  input  logic [DATA_W-1:0]       wb_data2,
  output logic                    we_A,
  output logic                    we_B,
  output logic [ADDR_W-1:0]       waddr_A,
  output logic [ADDR_W-1:0]       waddr_B,
  output logic [DATA_W-1:0]       wdata_A,
  output logic [DATA_W-1:0]       wdata_B,
  output logic                    src_A,
  output logic                    src_B,
  output logic [$clog2(DEPTH):0]  pend1,
  output logic [$clog2(DEPTH):0]  pend2,
  output logic                    idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  // Index 0/1 selects core 1/core 2 for FIFO state, and bank A/bank B for
  // round-robin pointers and write-port registers.
  logic [ENT_W-1:0]  mem_q   [2][DEPTH];
  logic [PTR_W-1:0]  wr_q    [2];
  logic [PTR_W-1:0]  wr_d    [2];
  logic [PTR_W-1:0]  rd_q    [2];
  logic [PTR_W-1:0]  rd_d    [2];
  logic [CNT_W-1:0]  cnt_q   [2];
  logic [CNT_W-1:0]  cnt_d   [2];
  logic              rr_q    [2];
  logic              rr_d    [2];
  logic              we_q    [2];
  logic              we_d    [2];
  logic [ADDR_W-1:0] waddr_q [2];
  logic [ADDR_W-1:0] waddr_d [2];
  logic [DATA_W-1:0] wdata_q [2];
  logic [DATA_W-1:0] wdata_d [2];
  logic              src_q   [2];
  logic              src_d   [2];

  logic              valid   [2];
  logic              push    [2];
  logic              pop     [2];
  logic              full    [2];
  logic              head_v  [2];
  logic              hbank   [2];
  logic [ENT_W-1:0]  in_ent  [2];
  logic [ENT_W-1:0]  head    [2];
  logic              contest;
  logic              win;

  // FIFO status, heads and accepted pushes
  always_comb begin
    valid[0]  = wb_valid1;
    valid[1]  = wb_valid2;
    in_ent[0] = {wb_bank1, wb_addr1, wb_data1};
    in_ent[1] = {wb_bank2, wb_addr2, wb_data2};
    for (int unsigned c = 0; c < 2; c++) begin
      full[c]   = (cnt_q[c] == CNT_W'(DEPTH));
      head_v[c] = (cnt_q[c] != '0);
      head[c]   = mem_q[c][rd_q[c]];
      hbank[c]  = head[c][ENT_W-1];
      push[c]   = valid[c] && !full[c];
    end
  end

  // Arbitration: pick which heads pop and load them onto their bank ports
  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      pop[c]     = head_v[c];
      rr_d[c]    = rr_q[c];
      we_d[c]    = 1'b0;
      waddr_d[c] = waddr_q[c];
      wdata_d[c] = wdata_q[c];
      src_d[c]   = src_q[c];
    end
    contest = head_v[0] && head_v[1] && (hbank[0] == hbank[1]);
    win     = hbank[0] ? rr_q[1] : rr_q[0];
    if (contest) begin
      pop[0]          = !win;
      pop[1]          = win;
      rr_d[hbank[0]]  = !win;
    end
    for (int unsigned c = 0; c < 2; c++) begin
      if (pop[c]) begin
        we_d[hbank[c]]    = 1'b1;
        waddr_d[hbank[c]] = head[c][ENT_W-2 -: ADDR_W];
        wdata_d[hbank[c]] = head[c][DATA_W-1:0];
        src_d[hbank[c]]   = (c == 1);
      end
    end
  end

  // FIFO pointer and occupancy updates
  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      wr_d[c]  = wr_q[c] + PTR_W'(push[c]);
      rd_d[c]  = rd_q[c] + PTR_W'(pop[c]);
      cnt_d[c] = cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
    end
  end

  // Control state and registered write ports, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_q[c]    <= '0;
        rd_q[c]    <= '0;
        cnt_q[c]   <= '0;
        rr_q[c]    <= 1'b0;
        we_q[c]    <= 1'b0;
        waddr_q[c] <= '0;
        wdata_q[c] <= '0;
        src_q[c]   <= 1'b0;
      end
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_q[c]    <= wr_d[c];
        rd_q[c]    <= rd_d[c];
        cnt_q[c]   <= cnt_d[c];
        rr_q[c]    <= rr_d[c];
        we_q[c]    <= we_d[c];
        waddr_q[c] <= waddr_d[c];
        wdata_q[c] <= wdata_d[c];
        src_q[c]   <= src_d[c];
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wr_q[c]] <= in_ent[c];
    end
  end

  assign wb_ready1 = !full[0];
  assign wb_ready2 = !full[1];
  assign we_A      = we_q[0];
  assign we_B      = we_q[1];
  assign waddr_A   = waddr_q[0];
  assign waddr_B   = waddr_q[1];
  assign wdata_A   = wdata_q[0];
  assign wdata_B   = wdata_q[1];
  assign src_A     = src_q[0];
  assign src_B     = src_q[1];
  assign pend1     = cnt_q[0];
  assign pend2     = cnt_q[1];
  assign idle      = !head_v[0] && !head_v[1] && !we_q[0] && !we_q[1];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: transaction-level model of the two core queues
// and per-bank priority produces expected writes into per-bank scoreboards;
// a negedge monitor pops and compares whenever a bank strobe appears.
module tb_rf_write_arbiter;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic wb_valid1, wb_valid2, wb_ready1, wb_ready2, wb_bank1, wb_bank2;
  logic [ADDR_W-1:0] wb_addr1, wb_addr2, waddr_A, waddr_B;
  logic [DATA_W-1:0] wb_data1, wb_data2, wdata_A, wdata_B;
  logic we_A, we_B, src_A, src_B, idle;
  logic [$clog2(DEPTH):0] pend1, pend2;

  rf_write_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wb_valid1(wb_valid1), .wb_valid2(wb_valid2),
    .wb_ready1(wb_ready1), .wb_ready2(wb_ready2),
    .wb_bank1(wb_bank1), .wb_bank2(wb_bank2),
    .wb_addr1(wb_addr1), .wb_addr2(wb_addr2),
    .wb_data1(wb_data1), .wb_data2(wb_data2),
    .we_A(we_A), .we_B(we_B),
    .waddr_A(waddr_A), .waddr_B(waddr_B),
    .wdata_A(wdata_A), .wdata_B(wdata_B),
    .src_A(src_A), .src_B(src_B),
    .pend1(pend1), .pend2(pend2), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              src;
  } exp_t;

  req_t q1[$];
  req_t q2[$];
  exp_t expq[2][$];
  int   prio[2];
  logic [ADDR_W-1:0] last_addr[2];
  logic [DATA_W-1:0] last_data[2];
  logic              last_src[2];
  bit   exp_we[2];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void issue(input req_t r, input bit src);
    exp_t e;
    int b;
    b      = r.bank ? 1 : 0;
    e.cyc  = cyc;
    e.addr = r.addr;
    e.data = r.data;
    e.src  = src;
    expq[b].push_back(e);
    last_addr[b] = r.addr;
    last_data[b] = r.data;
    last_src[b]  = src;
    exp_we[b]    = 1'b1;
  endfunction

  // Reference model: accept if the queue has room, issue queue heads,
  // resolve same-bank collisions with the per-bank priority core.
  always @(posedge clk or posedge rst) begin : model
    req_t r;
    bit acc1, acc2, g1, g2;
    int b;
    if (rst) begin
      q1.delete(); q2.delete();
      expq[0].delete(); expq[1].delete();
      for (int i = 0; i < 2; i++) begin
        prio[i] = 0; last_addr[i] = '0; last_data[i] = '0;
        last_src[i] = 1'b0; exp_we[i] = 1'b0;
      end
    end else begin
      cyc++;
      acc1 = wb_valid1 && (q1.size() < DEPTH);
      acc2 = wb_valid2 && (q2.size() < DEPTH);
      exp_we[0] = 1'b0;
      exp_we[1] = 1'b0;
      g1 = q1.size() > 0;
      g2 = q2.size() > 0;
      if (g1 && g2 && (q1[0].bank == q2[0].bank)) begin
        b = q1[0].bank ? 1 : 0;
        if (prio[b] == 0) begin g2 = 1'b0; prio[b] = 1; end
        else              begin g1 = 1'b0; prio[b] = 0; end
      end
      if (g1) begin issue(q1[0], 1'b0); void'(q1.pop_front()); end
      if (g2) begin issue(q2[0], 1'b1); void'(q2.pop_front()); end
      if (acc1) begin r.bank = wb_bank1; r.addr = wb_addr1; r.data = wb_data1; q1.push_back(r); end
      if (acc2) begin r.bank = wb_bank2; r.addr = wb_addr2; r.data = wb_data2; q2.push_back(r); end
    end
  end

  // Monitor: compare status every cycle, pop scoreboard on each strobe
  always @(negedge clk) begin : monitor
    logic              mwe[2];
    logic [ADDR_W-1:0] ma[2];
    logic [DATA_W-1:0] md[2];
    logic              ms[2];
    string             bn;
    exp_t              e;
    if (!rst) begin
      mwe[0] = we_A;    mwe[1] = we_B;
      ma[0]  = waddr_A; ma[1]  = waddr_B;
      md[0]  = wdata_A; md[1]  = wdata_B;
      ms[0]  = src_A;   ms[1]  = src_B;
      chk("pend1", 64'(pend1), 64'(q1.size()));
      chk("pend2", 64'(pend2), 64'(q2.size()));
      chk("ready1", 64'(wb_ready1), 64'(q1.size() < DEPTH));
      chk("ready2", 64'(wb_ready2), 64'(q2.size() < DEPTH));
      chk("idle", 64'(idle), 64'(q1.size() == 0 && q2.size() == 0 && !exp_we[0] && !exp_we[1]));
      for (int b = 0; b < 2; b++) begin
        bn = (b == 0) ? "A" : "B";
        chk({"we_", bn}, 64'(mwe[b]), 64'(exp_we[b]));
        if (mwe[b] === 1'b1) begin
          if (expq[b].size() == 0) begin
            chk({"unexpected_write_", bn}, 64'(1), 64'(0));
          end else begin
            e = expq[b].pop_front();
            chk({"cycle_", bn}, 64'(cyc), 64'(e.cyc));
            chk({"waddr_", bn}, 64'(ma[b]), 64'(e.addr));
            chk({"wdata_", bn}, 64'(md[b]), 64'(e.data));
            chk({"src_", bn}, 64'(ms[b]), 64'(e.src));
          end
        end else begin
          chk({"hold_waddr_", bn}, 64'(ma[b]), 64'(last_addr[b]));
          chk({"hold_wdata_", bn}, 64'(md[b]), 64'(last_data[b]));
          chk({"hold_src_", bn}, 64'(ms[b]), 64'(last_src[b]));
        end
      end
    end
  end

  task automatic cycle(input bit v1, input bit b1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input bit v2, input bit b2, input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2);
    wb_valid1 = v1; wb_bank1 = b1; wb_addr1 = a1; wb_data1 = d1;
    wb_valid2 = v2; wb_bank2 = b2; wb_addr2 = a2; wb_data2 = d2;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    cycle(0, 0, '0, '0, 0, 0, '0, '0);
    while ((q1.size() != 0 || q2.size() != 0 || exp_we[0] || exp_we[1]) && n < 50) begin
      cycle(0, 0, '0, '0, 0, 0, '0, '0);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 64'(1), 64'(0));
    cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    wb_valid1 = 0; wb_valid2 = 0; wb_bank1 = 0; wb_bank2 = 0;
    wb_addr1 = '0; wb_addr2 = '0; wb_data1 = '0; wb_data2 = '0;
    #3;
    chk("rst_we_A", 64'(we_A), 64'(0));
    chk("rst_we_B", 64'(we_B), 64'(0));
    chk("rst_waddr_A", 64'(waddr_A), 64'(0));
    chk("rst_wdata_B", 64'(wdata_B), 64'(0));
    chk("rst_src_B", 64'(src_B), 64'(0));
    chk("rst_pend1", 64'(pend1), 64'(0));
    chk("rst_ready2", 64'(wb_ready2), 64'(1));
    chk("rst_idle", 64'(idle), 64'(1));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single write to bank A
    cycle(1, 0, 5'd3, 32'hDEADBEEF, 0, 0, '0, '0);
    drain();
    chk("single_idle", 64'(idle), 64'(1));

    // Parallel banks in one cycle
    cycle(1, 0, 5'd5, 32'h11, 1, 1, 5'd5, 32'h22);
    drain();

    // Contention on bank B
    for (int i = 0; i < 4; i++)
      cycle(1, 1, 5'($urandom), $urandom, 1, 1, 5'($urandom), $urandom);
    drain();

    // Backpressure: both cores hammer bank A
    for (int i = 0; i < 14; i++) begin
      cycle(1, 0, 5'($urandom), $urandom, 1, 0, 5'($urandom), $urandom);
      if (q1.size() == DEPTH) chk("bp_ready1_low", 64'(wb_ready1), 64'(0));
    end
    drain();

    // Wrap-around: twelve sequential uncontested writes from core 2
    for (int i = 0; i < 12; i++)
      cycle(0, 0, '0, '0, 1, 1, 5'(i), 32'(i));
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 2) == 0, 1'($urandom), 5'($urandom), $urandom,
            ($urandom % 3) != 0, 1'($urandom), 5'($urandom), $urandom);
    drain();

    // Reset mid-stream with pend1 = 3 and a bank-A strobe in flight
    n = 0;
    do begin
      cycle(1, 0, 5'($urandom), $urandom, 1, 0, 5'($urandom), $urandom);
      n++;
    end while (!(q1.size() == 3 && exp_we[0]) && n < 20);
    if (n >= 20) chk("midrst_setup_timeout", 64'(1), 64'(0));
    #2 rst = 1'b1;
    #1;
    chk("midrst_we_A", 64'(we_A), 64'(0));
    chk("midrst_we_B", 64'(we_B), 64'(0));
    chk("midrst_pend1", 64'(pend1), 64'(0));
    chk("midrst_pend2", 64'(pend2), 64'(0));
    wb_valid1 = 0; wb_valid2 = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", 64'(idle), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
